// File: rtl/sha_stream_cipher.sv
// Word-serial stream cipher engine: reads src words and key words, writes
// rotl(d^k) (encrypt) or rotr(d)^k (decrypt) to dst, one word per RD/WAIT/WR pass.
//
// state | meaning
// IDLE  | waiting for a command; all memory outputs parked at zero
// RD    | present src and key addresses for word i
// WAIT  | hold read addresses for the memory latency; last cycle captures read data
// WR    | write the result for word i to dst_base+i
// DONE  | job complete; holds until start returns to 00
// ERR   | illegal command or zero length; holds until start returns to 00
module sha_stream_cipher #(
  parameter int DATA_W  = 32,
  parameter int DADDR_W = 9,
  parameter int KADDR_W = 8,
  parameter int KEY_LEN = 4,
  parameter int ROT     = 1,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         start,
  input  logic [DADDR_W-1:0] length,
  input  logic [DADDR_W-1:0] src_base,
  input  logic [DADDR_W-1:0] dst_base,
  input  logic [KADDR_W-1:0] key_base,
  input  logic [DATA_W-1:0]  key_out,
  input  logic [DATA_W-1:0]  data_out,
  output logic [KADDR_W-1:0] key_addr,
  output logic [DADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0]  data_in,
  output logic               we,
  output logic [2:0]         stop
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE, ERR} state_t;

  localparam logic [KADDR_W-1:0] KEY_LAST = KADDR_W'(KEY_LEN - 1);
  localparam logic [2:0]         LAT_LOAD = 3'(RD_LAT - 1);

  state_t               state_q, state_d;
  logic                 enc_q;
  logic [DADDR_W-1:0]   len_q, src_q, dst_q, i_q;
  logic [KADDR_W-1:0]   kbase_q, kidx_q;
  logic [2:0]           lat_q;
  logic [DATA_W-1:0]    dword_q, kword_q;
  logic                 cmd_ok, word_last;
  logic [DATA_W-1:0]    mix, enc_res, dec_rot, result;

  assign cmd_ok    = (start == 2'b01 || start == 2'b10) && (length != '0);
  assign word_last = (i_q == len_q - DADDR_W'(1));

  // A zero shift amount degenerates cleanly: the right shift by DATA_W yields zero.
  assign mix     = dword_q ^ kword_q;
  assign enc_res = (mix << ROT) | (mix >> (DATA_W - ROT));
  assign dec_rot = (dword_q >> ROT) | (dword_q << (DATA_W - ROT));
  assign result  = enc_q ? enc_res : (dec_rot ^ kword_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      enc_q   <= 1'b0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      kbase_q <= '0;
      i_q     <= '0;
      kidx_q  <= '0;
      lat_q   <= '0;
      dword_q <= '0;
      kword_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (cmd_ok) begin
          enc_q   <= (start == 2'b01);
          len_q   <= length;
          src_q   <= src_base;
          dst_q   <= dst_base;
          kbase_q <= key_base;
          i_q     <= '0;
          kidx_q  <= '0;
        end
        RD: lat_q <= LAT_LOAD;
        WAIT: begin
          if (lat_q == '0) begin
            dword_q <= data_out;
            kword_q <= key_out;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        WR: if (!word_last) begin
          i_q    <= i_q + DADDR_W'(1);
          kidx_q <= (kidx_q == KEY_LAST) ? '0 : kidx_q + KADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    stop      = 3'b000;
    we        = 1'b0;
    data_in   = '0;
    data_addr = '0;
    key_addr  = '0;
    case (state_q)
      IDLE: begin
        if (start == 2'b11 || (start != 2'b00 && length == '0)) state_d = ERR;
        else if (start != 2'b00)                                state_d = RD;
      end
      RD: begin
        stop      = 3'b001;
        data_addr = src_q + i_q;
        key_addr  = kbase_q + kidx_q;
        state_d   = WAIT;
      end
      WAIT: begin
        stop      = 3'b001;
        data_addr = src_q + i_q;
        key_addr  = kbase_q + kidx_q;
        if (lat_q == '0) state_d = WR;
      end
      WR: begin
        stop      = 3'b001;
        we        = 1'b1;
        data_in   = result;
        data_addr = dst_q + i_q;
        state_d   = word_last ? DONE : RD;
      end
      DONE: begin
        stop = 3'b010;
        if (start == 2'b00) state_d = IDLE;
      end
      ERR: begin
        stop = 3'b100;
        if (start == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha_stream_cipher.sv
// Directed bench for sha_stream_cipher: behavioural data/key memories with
// one-cycle registered reads, a table of single-word vectors and multi-cycle sequences.
module tb_sha_stream_cipher;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start;
  logic [8:0]  length, src_base, dst_base, data_addr;
  logic [7:0]  key_base, key_addr;
  logic [31:0] key_out, data_out, data_in;
  logic        we;
  logic [2:0]  stop;

  sha_stream_cipher dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .src_base(src_base), .dst_base(dst_base), .key_base(key_base),
    .key_out(key_out), .data_out(data_out), .key_addr(key_addr),
    .data_addr(data_addr), .data_in(data_in), .we(we), .stop(stop)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [512];
  logic [31:0] kmem [256];
  logic [31:0] dpipe, kpipe;

  always @(posedge clk) begin
    if (we) dmem[data_addr] <= data_in;
    dpipe <= dmem[data_addr];
    kpipe <= kmem[key_addr];
  end
  assign data_out = dpipe;
  assign key_out  = kpipe;

  // Logs the first address pair of each read phase and every write address.
  int         busy_total = 0, we_total = 0, bad_total = 0;
  bit         rd_armed = 1'b1;
  logic [8:0] rd_log[$], wr_log[$];
  logic [7:0] key_log[$];

  always @(negedge clk) begin
    if (stop == 3'b001) busy_total++;
    if (!we && data_in != 32'h0) bad_total++;
    if (we && stop != 3'b001) bad_total++;
    if (we) begin
      we_total++;
      wr_log.push_back(data_addr);
      rd_armed = 1'b1;
    end else if (stop == 3'b001 && rd_armed) begin
      rd_log.push_back(data_addr);
      key_log.push_back(key_addr);
      rd_armed = 1'b0;
    end else if (stop != 3'b001) begin
      rd_armed = 1'b1;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] enc_m(input logic [31:0] d, input logic [31:0] k);
    logic [31:0] x;
    x = d ^ k;
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] dec_m(input logic [31:0] d, input logic [31:0] k);
    return {d[0], d[31:1]} ^ k;
  endfunction

  // Issues a command, scrambles start/length/bases while busy, returns at DONE/ERR.
  task automatic run_op(input logic [1:0] cmd, input logic [8:0] len, input logic [8:0] src,
                        input logic [8:0] dst, input logic [7:0] kb,
                        output int busy, output int wes, output logic [2:0] fin);
    int b0, w0;
    @(negedge clk);
    rd_log.delete(); wr_log.delete(); key_log.delete();
    b0 = busy_total; w0 = we_total;
    start = cmd; length = len; src_base = src; dst_base = dst; key_base = kb;
    fin = 3'b000;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (stop == 3'b010 || stop == 3'b100) begin
        fin = stop;
        break;
      end
      start = 2'b11; length = 9'd0; src_base = 9'h1AA; dst_base = 9'h0F0; key_base = 8'h55;
    end
    if (fin == 3'b000) chk("op_timeout", {29'h0, stop}, 32'h2);
    busy = busy_total - b0;
    wes  = we_total - w0;
  endtask

  task automatic release_start();
    start = 2'b00;
    @(negedge clk);
    chk("release_idle", {29'h0, stop}, 32'h0);
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] data;
    logic [31:0] key;
    logic [31:0] exp;
    logic [8:0]  addr;
  } vec_t;

  vec_t        vecs [6];
  int          busy, wes, b0;
  logic [2:0]  fin;
  logic [31:0] orig [6];

  initial begin
    vecs[0] = '{2'b01, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD, 9'd0};
    vecs[1] = '{2'b10, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000001, 9'd0};
    vecs[2] = '{2'b01, 32'h80000000, 32'h00000000, 32'h00000001, 9'd7};
    vecs[3] = '{2'b10, 32'h00000001, 32'h00000000, 32'h80000000, 9'd7};
    vecs[4] = '{2'b01, 32'h12345678, 32'h0F0F0F0F, 32'h3A76B2EE, 9'd300};
    vecs[5] = '{2'b10, 32'h3A76B2EE, 32'h0F0F0F0F, 32'h12345678, 9'd300};

    reset = 1'b1; start = 2'b00; length = '0; src_base = '0; dst_base = '0; key_base = '0;
    for (int a = 0; a < 512; a++) dmem[a] <= 32'h5A5A0000 + 32'(a);
    for (int k = 0; k < 256; k++) kmem[k] <= (32'h01010101 * 32'(k)) ^ 32'h0F0F0000;
    start = 2'b01; length = 9'd3;
    repeat (3) @(negedge clk);
    chk("reset_stop", {29'h0, stop}, 32'h0);
    chk("reset_we", {31'h0, we}, 32'h0);
    chk("reset_data_in", data_in, 32'h0);
    chk("reset_addrs", {15'h0, data_addr, key_addr}, 32'h0);
    start = 2'b00;
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      dmem[vecs[v].addr] <= vecs[v].data;
      kmem[0] <= vecs[v].key;
      run_op(vecs[v].cmd, 9'd1, vecs[v].addr, vecs[v].addr, 8'd0, busy, wes, fin);
      chk($sformatf("vec%0d_result", v), dmem[vecs[v].addr], vecs[v].exp);
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd3);
      chk($sformatf("vec%0d_stop", v), {29'h0, fin}, 32'h2);
      chk($sformatf("vec%0d_we", v), 32'(wes), 32'd1);
      release_start();
    end

    // Completion must hold while start stays asserted and not retrigger.
    run_op(2'b01, 9'd1, 9'd50, 9'd50, 8'd0, busy, wes, fin);
    start = 2'b01;
    b0 = busy_total;
    repeat (4) @(negedge clk);
    chk("hold_done", {29'h0, stop}, 32'h2);
    chk("hold_no_retrigger", 32'(busy_total - b0), 32'd0);
    release_start();

    // Key index wraps after KEY_LEN words.
    kmem[0] <= 32'h0F0F0000;
    @(negedge clk);
    for (int j = 0; j < 6; j++) orig[j] = dmem[20 + j];
    run_op(2'b01, 9'd6, 9'd20, 9'd20, 8'd0, busy, wes, fin);
    chk("kwrap_busy", 32'(busy), 32'd18);
    chk("kwrap_we", 32'(wes), 32'd6);
    chk("kwrap_nkeys", 32'(key_log.size()), 32'd6);
    if (key_log.size() == 6)
      for (int j = 0; j < 6; j++) chk($sformatf("kwrap_key%0d", j), {24'h0, key_log[j]}, 32'(j % 4));
    for (int j = 0; j < 6; j++)
      chk($sformatf("kwrap_data%0d", j), dmem[20 + j], enc_m(orig[j], kmem[j % 4]));
    release_start();

    // Source address wraps past the top of data memory.
    orig[0] = dmem[510]; orig[1] = dmem[511]; orig[2] = dmem[0];
    run_op(2'b10, 9'd3, 9'd510, 9'd100, 8'd0, busy, wes, fin);
    chk("awrap_nrd", 32'(rd_log.size()), 32'd3);
    chk("awrap_nwr", 32'(wr_log.size()), 32'd3);
    if (rd_log.size() == 3 && wr_log.size() == 3) begin
      chk("awrap_rd", {5'h0, rd_log[0], rd_log[1], rd_log[2]}, {5'h0, 9'd510, 9'd511, 9'd0});
      chk("awrap_wr", {5'h0, wr_log[0], wr_log[1], wr_log[2]}, {5'h0, 9'd100, 9'd101, 9'd102});
    end
    for (int j = 0; j < 3; j++)
      chk($sformatf("awrap_data%0d", j), dmem[100 + j], dec_m(orig[j], kmem[j]));
    release_start();

    run_op(2'b11, 9'd5, 9'd0, 9'd0, 8'd0, busy, wes, fin);
    chk("err_illegal_stop", {29'h0, fin}, 32'h4);
    chk("err_illegal_we", 32'(wes), 32'd0);
    release_start();
    run_op(2'b01, 9'd0, 9'd0, 9'd0, 8'd0, busy, wes, fin);
    chk("err_len0_stop", {29'h0, fin}, 32'h4);
    chk("err_len0_we", 32'(wes), 32'd0);
    release_start();

    // Reset during the second RD leaves only the first destination word written.
    for (int j = 0; j < 4; j++) orig[j] = dmem[200 + j];
    b0 = we_total;
    @(negedge clk);
    start = 2'b01; length = 9'd4; src_base = 9'd200; dst_base = 9'd200; key_base = 8'd0;
    @(negedge clk);
    start = 2'b00;
    for (int c = 0; c < 20 && !we; c++) @(negedge clk);
    chk("rst_first_we", {31'h0, we}, 32'h1);
    @(negedge clk);
    chk("rst_in_rd", {29'h0, stop}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_stop", {29'h0, stop}, 32'h0);
    chk("rst_we", {31'h0, we}, 32'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_writes", 32'(we_total - b0), 32'd1);
    chk("rst_word0", dmem[200], enc_m(orig[0], kmem[0]));
    for (int j = 1; j < 4; j++) chk($sformatf("rst_word%0d", j), dmem[200 + j], orig[j]);
    chk("rst_idle", {29'h0, stop}, 32'h0);

    chk("data_in_we_rules", 32'(bad_total), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
